// File: rtl/emitter_uart.sv
// Purpose:      transmit-only 8N1 UART serializer; one byte per valid/ready handshake.
// Latency:      TX goes low one cycle after acceptance; each bit lasts CLKS_PER_BIT cycles, 10 bits per frame.
// Backpressure: o_ready is low for the whole frame; i_valid while busy is dropped, never queued.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset (aborts any frame, line returns to mark)
//   i_data     byte to send, sampled only on the accepting edge
//   i_valid    send request
//   o_ready    idle and able to accept (inverted, this is the CPU "busy" bit)
//   o_uart_tx  serial line, idle level 1
module emitter_uart #(
    parameter int clk_freq_hz = 12000000,
    parameter int baud_rate   = 9600
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    // A bit period shorter than two clocks cannot be timed by the down-counter.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("emitter_uart: clk_freq_hz / baud_rate must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_ready;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [2:0]       w_bit_idx;
    logic [7:0]       w_shift;
    logic             w_tx;
    logic             w_ready;
    logic             w_bit_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
            r_ready   <= w_ready;
        end
    end

    // The counter runs CLKS_PER_BIT-1 down to 0; the edge that sees 0 is the
    // bit boundary, where the next bit is driven and the counter reloads.
    assign w_bit_done = (r_cnt == '0);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_ready   = r_ready;

        case (r_state)
            S_IDLE: begin
                w_tx    = 1'b1;
                w_ready = 1'b1;
                if (i_valid && r_ready) begin
                    w_state   = S_START;
                    w_tx      = 1'b0;
                    w_ready   = 1'b0;
                    w_shift   = i_data;
                    w_cnt     = CNT_LOAD;
                    w_bit_idx = '0;
                end
            end

            S_START: begin
                if (w_bit_done) begin
                    w_state   = S_DATA;
                    w_cnt     = CNT_LOAD;
                    w_bit_idx = '0;
                    w_tx      = r_shift[0];
                    w_shift   = {1'b0, r_shift[7:1]};
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt = CNT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_tx      = r_shift[0];
                        w_shift   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end

            S_STOP: begin
                // Full stop bit is held; ready only rises once it has elapsed.
                if (w_bit_done) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_tx    = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_ready = 1'b1;
            end
        endcase
    end

    assign o_uart_tx = r_tx;
    assign o_ready   = r_ready;

endmodule

// File: tb/tb_emitter_uart.sv
// Purpose:      self-checking bench for emitter_uart with CLKS_PER_BIT = 10.
// Latency:      compares TX/ready against a frame-timing model every cycle.
// Backpressure: drives i_valid at negedges; extra requests during a frame must be ignored.
module tb_emitter_uart;

    localparam int CPB = 10;

    logic       clk     = 1'b0;
    logic       resetn  = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_uart_tx;

    emitter_uart #(
        .clk_freq_hz(1000000),
        .baud_rate  (100000)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_uart_tx(o_uart_tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame started at edge S occupies edges S..S+99; the
    // bit on the line is slot (edge-S)/CPB of {stop, byte, start}.
    int         m_edge  = 0;
    int         m_start = 0;
    bit         m_busy  = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    bit         chk_en  = 1'b0;

    always @(posedge clk) begin
        m_edge++;
        if (!resetn) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (i_valid) begin
                m_busy  = 1'b1;
                m_start = m_edge;
                m_byte  = i_data;
            end
        end else if (m_edge - m_start == 10 * CPB) begin
            m_busy = 1'b0;
        end
        chk_en = 1'b1;
    end

    function automatic logic exp_tx();
        int slot;
        if (!m_busy) return 1'b1;
        slot = (m_edge - m_start) / CPB;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_cycle", {31'd0, o_uart_tx}, {31'd0, exp_tx()});
            check("ready_cycle", {31'd0, o_ready}, {31'd0, !m_busy});
        end
    end

    // Request a byte at a negedge; returns at the negedge just after the
    // accepting edge (frame offset d = 0). i_valid is left high.
    task automatic start_send(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starting at d = 0, samples TX mid-bit and counts busy cycles until
    // ready returns. Optionally injects a one-cycle 0xFF request at pulse_d
    // and drops i_valid at drop_d.
    task automatic run_frame(input int pulse_d, input int drop_d,
                             output logic [9:0] bits, output int busy_len);
        bits     = '0;
        busy_len = 0;
        for (int d = 0; d < 20 * CPB; d++) begin
            if (pulse_d >= 0 && d == pulse_d) begin
                i_valid = 1'b1;
                i_data  = 8'hFF;
            end
            if (pulse_d >= 0 && d == pulse_d + 1) i_valid = 1'b0;
            if (drop_d >= 0 && d == drop_d) i_valid = 1'b0;
            if ((d % CPB) == CPB / 2 && d < 10 * CPB) bits[d / CPB] = o_uart_tx;
            if (o_ready) break;
            busy_len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic [9:0] bits_b;
        int         len;
        int         len_b;
        int         idle_ok;

        // Reset and idle stability
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, o_uart_tx}, 32'd1);
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        resetn = 1'b1;
        idle_ok = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_uart_tx === 1'b1 && o_ready === 1'b1) idle_ok++;
        end
        check("idle_stable_50", idle_ok, 32'd50);

        // 0x55 with a single-cycle request
        start_send(8'h55);
        i_valid = 1'b0;
        run_frame(-1, -1, bits, len);
        check("frame_55_bits", {22'd0, bits}, {22'd0, 10'b1010101010});
        check("frame_55_busy", len, 32'd100);
        check("frame_55_end_tx", {31'd0, o_uart_tx}, 32'd1);

        // 0xA3 latched; input changes to 0x00 right after acceptance
        start_send(8'hA3);
        i_data = 8'h00;
        run_frame(-1, 50, bits, len);
        check("frame_a3_bits", {22'd0, bits}, {22'd0, 10'b1101000110});
        check("frame_a3_busy", len, 32'd100);

        // Request during a frame is ignored; no second frame follows
        start_send(8'h3C);
        i_valid = 1'b0;
        run_frame(30, -1, bits, len);
        check("frame_3c_bits", {22'd0, bits}, {22'd0, 10'b1001111000});
        check("frame_3c_busy", len, 32'd100);
        idle_ok = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_uart_tx === 1'b1 && o_ready === 1'b1) idle_ok++;
        end
        check("no_extra_frame", idle_ok, 32'd30);

        // Back-to-back "AB" with i_valid held high
        start_send(8'h41);
        i_data = 8'h42;
        run_frame(-1, -1, bits, len);
        check("frame_a_busy", len, 32'd100);
        check("gap_ready_high", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        check("b2b_start_tx", {31'd0, o_uart_tx}, 32'd0);
        check("b2b_start_ready", {31'd0, o_ready}, 32'd0);
        i_valid = 1'b0;
        run_frame(-1, -1, bits_b, len_b);
        check("frame_a_bits", {22'd0, bits}, {22'd0, 10'b1010000010});
        check("frame_b_bits", {22'd0, bits_b}, {22'd0, 10'b1010000100});
        check("decode_A", {24'd0, bits[8:1]}, 32'h41);
        check("decode_B", {24'd0, bits_b[8:1]}, 32'h42);
        check("frame_b_busy", len_b, 32'd100);

        // Reset in the middle of data bit 3, then a clean frame
        start_send(8'h00);
        i_valid = 1'b0;
        repeat (45) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_tx", {31'd0, o_uart_tx}, 32'd1);
        check("midreset_ready", {31'd0, o_ready}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        start_send(8'h0F);
        i_valid = 1'b0;
        run_frame(-1, -1, bits, len);
        check("frame_0f_bits", {22'd0, bits}, {22'd0, 10'b1000011110});
        check("frame_0f_busy", len, 32'd100);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/emitter_uart.md
Name: emitter_uart

Overview:
- Transmit-only UART serializer. Takes one byte per valid/ready handshake and emits it as an 8N1 frame on a single TX line.
- Sits on the SoC memory-mapped IO path: a CPU store to the UART data register pulses i_valid, and the inverted o_ready is exposed as the "busy" status bit.
- No receive path, parity or FIFO.

Parameters:
- clk_freq_hz, 12000000, frequency of clk in Hz.
- baud_rate, 9600, serial bit rate in bits/s.
- Derived constant CLKS_PER_BIT = clk_freq_hz / baud_rate, integer truncating division. It must be at least 2; elaboration fails otherwise.
- Derived bit-counter width = clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- i_data  input  8  byte to transmit; sampled only on acceptance.
- i_valid  input  1  request to send i_data.
- o_ready  output  1  high when idle and able to accept a byte.
- o_uart_tx  output  1  serial line; idle/mark level is 1.

Behaviour:
- Reset: on a rising edge with resetn=0:
  - o_uart_tx=1, o_ready=1.
  - Shift register, bit index and baud counter cleared.
  - State=IDLE.
  - This applies mid-frame: the frame is aborted and the line returns to 1 on the next cycle.
- Handshake: a byte is accepted on a rising edge where i_valid=1 and o_ready=1.
  - i_valid while o_ready=0 is ignored; no queuing, no error flag.
  - i_data may change freely after acceptance.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT clk cycles.
  - Total frame length is 10*CLKS_PER_BIT cycles.
- Timing, with acceptance at edge N:
  - At edge N, register o_uart_tx<=0, o_ready<=0, latch i_data, and load the baud counter.
  - o_uart_tx is low from cycle N+1.
  - Data bit k (k=0..7) is driven from edge N+(k+1)*CLKS_PER_BIT.
  - The stop bit is driven from edge N+9*CLKS_PER_BIT.
  - o_ready<=1 at edge N+10*CLKS_PER_BIT, with o_uart_tx remaining 1.
- States:
  - IDLE: ready=1, tx=1. Moves to START on acceptance.
  - START: moves to DATA after CLKS_PER_BIT cycles.
  - DATA: moves to STOP after 8 bit periods.
  - STOP: moves to IDLE after CLKS_PER_BIT cycles.
- Back-to-back: if i_valid stays high, the next byte is accepted on the first edge where o_ready=1.
  - That is edge N+10*CLKS_PER_BIT+1, because o_ready becomes visible one cycle after edge N+10*CLKS_PER_BIT.
  - The idle gap between frames is 1 cycle of mark level; the stop bit is never shortened.
- o_uart_tx and o_ready are registered outputs with no combinational path from inputs.
- The baud counter counts down from CLKS_PER_BIT-1 to 0. It reloads at each bit boundary and has no drift accumulation across a frame.

Test Plan:
- Reset, with clk_freq_hz=1000000 and baud_rate=100000 (CLKS_PER_BIT=10) -> after resetn low for 2 cycles and then high: o_uart_tx=1, o_ready=1, stable for 50 cycles with i_valid=0.
- Send 0x55 with a 1-cycle i_valid pulse -> o_ready low for exactly 100 cycles. Sampling tx mid-bit (cycles N+5+10k) gives 0,1,0,1,0,1,0,1,0,1. o_ready returns high with tx=1.
- Send 0xA3 with i_valid held high and i_data changed to 0x00 one cycle after acceptance -> serialized bits are 0,1,1,0,0,0,1,0,1,1, i.e. the latched byte is sent.
- Pulse i_valid with 0xFF during a frame in progress -> ignored. Only the original byte appears, and no second frame follows.
- Hold i_valid high with bytes 0x41 then 0x42 -> two complete frames; the second start bit begins 1 cycle after o_ready rises. Decoded output is "AB".
- Assert resetn=0 at mid-data-bit 3 of a 0x00 frame -> the next cycle has tx=1 and ready=1. A subsequent send of 0x0F completes a correct 100-cycle frame.
